// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter: owner encoding,
// default widths and a helper that names the opposite requester.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W    = 14;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_BURST_MAX = 8;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_LDR  = 2'b10
    } owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_CPU) ? OWN_LDR : OWN_CPU;
    endfunction

endpackage

// File: rtl/dmem_arb_fsm.sv
// Ownership/burst-count state and the combinational grant select for the
// two memory requesters.
module dmem_arb_fsm
    import dmem_arb_pkg::*;
#(
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic c_req,
    input  logic l_req,
    output logic gnt_c,
    output logic gnt_l
);

    localparam int              CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    owner_t            owner_q, owner_d;
    owner_t            win;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_IDLE;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // The burst limit only matters under contention; a lone requester always wins.
    always_comb begin
        win = OWN_IDLE;
        if (c_req && l_req) begin
            if (owner_q == OWN_IDLE)
                win = OWN_CPU;
            else if (cnt_q < CNT_MAX)
                win = owner_q;
            else
                win = other_owner(owner_q);
        end else if (c_req) begin
            win = OWN_CPU;
        end else if (l_req) begin
            win = OWN_LDR;
        end
        if (rst)
            win = OWN_IDLE;
        gnt_c = (win == OWN_CPU);
        gnt_l = (win == OWN_LDR);
    end

    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (win == OWN_IDLE) begin
            owner_d = OWN_IDLE;
            cnt_d   = '0;
        end else if (win == owner_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            owner_d = win;
            cnt_d   = CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory shared between the CPU load/store path and a
// loader; one access per cycle, read data returned one cycle after issue.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_din,
    input  logic [DATA_W-1:0] m_dout
);

    logic c_rvalid_q, c_rvalid_d;
    logic l_rvalid_q, l_rvalid_d;

    dmem_arb_fsm #(.BURST_MAX(BURST_MAX)) u_fsm (
        .clk   (clk),
        .rst   (rst),
        .c_req (c_req),
        .l_req (l_req),
        .gnt_c (c_gnt),
        .gnt_l (l_gnt)
    );

    always_comb begin
        m_we   = 1'b0;
        m_addr = '0;
        m_din  = '0;
        if (c_gnt) begin
            m_we   = c_we;
            m_addr = c_addr;
            m_din  = c_wdata;
        end else if (l_gnt) begin
            m_we   = l_we;
            m_addr = l_addr;
            m_din  = l_wdata;
        end
    end

    assign m_en    = c_gnt | l_gnt;
    // Grants are already forced low in reset; the explicit term keeps stall low too.
    assign c_stall = c_req & ~c_gnt & ~rst;

    always_comb begin
        c_rvalid_d = c_gnt & ~c_we;
        l_rvalid_d = l_gnt & ~l_we;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
        end else begin
            c_rvalid_q <= c_rvalid_d;
            l_rvalid_q <= l_rvalid_d;
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign l_rvalid = l_rvalid_q;
    assign c_rdata  = m_dout;
    assign l_rdata  = m_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-scenario tasks plus read-data
// scoreboards fed at grant time and drained when rvalid appears.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk, rst;
    logic          c_req, c_we, l_req, l_we;
    logic [AW-1:0] c_addr, l_addr;
    logic [DW-1:0] c_wdata, l_wdata;
    logic          c_gnt, c_stall, c_rvalid, l_gnt, l_rvalid;
    logic [DW-1:0] c_rdata, l_rdata;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din, m_dout;

    logic          b_c_req, b_c_we, b_l_req, b_l_we;
    logic [AW-1:0] b_c_addr, b_l_addr;
    logic [DW-1:0] b_c_wdata, b_l_wdata;
    logic          b_c_gnt, b_c_stall, b_c_rvalid, b_l_gnt, b_l_rvalid;
    logic [DW-1:0] b_c_rdata, b_l_rdata;
    logic          b_m_en, b_m_we;
    logic [AW-1:0] b_m_addr;
    logic [DW-1:0] b_m_din, b_m_dout;

    logic [DW-1:0] mem0 [0:(1<<AW)-1];
    logic [DW-1:0] mem1 [0:(1<<AW)-1];

    logic [DW-1:0] exp_c[$], exp_l[$], exp_bc[$], exp_bl[$];
    logic [DW-1:0] ev_c, ev_l, ev_bc, ev_bl;
    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(1)) dut1 (
        .clk(clk), .rst(rst),
        .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr), .c_wdata(b_c_wdata),
        .c_gnt(b_c_gnt), .c_stall(b_c_stall), .c_rvalid(b_c_rvalid), .c_rdata(b_c_rdata),
        .l_req(b_l_req), .l_we(b_l_we), .l_addr(b_l_addr), .l_wdata(b_l_wdata),
        .l_gnt(b_l_gnt), .l_rvalid(b_l_rvalid), .l_rdata(b_l_rdata),
        .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_din(b_m_din), .m_dout(b_m_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port memories, write-first ordering across cycles.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem0[m_addr] <= m_din;
            else      m_dout <= mem0[m_addr];
        end
        if (b_m_en) begin
            if (b_m_we) mem1[b_m_addr] <= b_m_din;
            else        b_m_dout <= mem1[b_m_addr];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (c_rvalid) begin
                checks++;
                if (exp_c.size() == 0) begin
                    errors++;
                    $display("FAIL c_rvalid_unexpected got=%h", c_rdata);
                end else begin
                    ev_c = exp_c.pop_front();
                    if (c_rdata !== ev_c) begin
                        errors++;
                        $display("FAIL c_rdata got=%h exp=%h", c_rdata, ev_c);
                    end
                end
            end
            if (l_rvalid) begin
                checks++;
                if (exp_l.size() == 0) begin
                    errors++;
                    $display("FAIL l_rvalid_unexpected got=%h", l_rdata);
                end else begin
                    ev_l = exp_l.pop_front();
                    if (l_rdata !== ev_l) begin
                        errors++;
                        $display("FAIL l_rdata got=%h exp=%h", l_rdata, ev_l);
                    end
                end
            end
            if (b_c_rvalid) begin
                checks++;
                if (exp_bc.size() == 0) begin
                    errors++;
                    $display("FAIL b1_c_rvalid_unexpected got=%h", b_c_rdata);
                end else begin
                    ev_bc = exp_bc.pop_front();
                    if (b_c_rdata !== ev_bc) begin
                        errors++;
                        $display("FAIL b1_c_rdata got=%h exp=%h", b_c_rdata, ev_bc);
                    end
                end
            end
            if (b_l_rvalid) begin
                checks++;
                if (exp_bl.size() == 0) begin
                    errors++;
                    $display("FAIL b1_l_rvalid_unexpected got=%h", b_l_rdata);
                end else begin
                    ev_bl = exp_bl.pop_front();
                    if (b_l_rdata !== ev_bl) begin
                        errors++;
                        $display("FAIL b1_l_rdata got=%h exp=%h", b_l_rdata, ev_bl);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 14'h3FF; c_wdata = 32'h0;
        l_req = 1'b1; l_we = 1'b1; l_addr = 14'h3FE; l_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({c_gnt, l_gnt, m_en, c_rvalid, l_rvalid, c_stall} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs got={gnt_c,gnt_l,m_en,crv,lrv,stall}=%b exp=000000",
                         {c_gnt, l_gnt, m_en, c_rvalid, l_rvalid, c_stall});
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (c_gnt !== 1'b1 || l_gnt !== 1'b0 || m_we !== 1'b1 || m_addr !== 14'h3FF) begin
            errors++;
            $display("FAIL reset_first_grant got c_gnt=%b l_gnt=%b m_we=%b m_addr=%h exp 1 0 1 3ff",
                     c_gnt, l_gnt, m_we, m_addr);
        end
        @(posedge clk); #1;
        c_req = 1'b0; l_req = 1'b0;
    endtask

    task automatic test_cpu_alone();
        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 14'h010; c_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (c_gnt !== 1'b1 || m_we !== 1'b1 || m_addr !== 14'h010 || m_din !== 32'hDEADBEEF || c_stall !== 1'b0) begin
            errors++;
            $display("FAIL cpu_store got gnt=%b we=%b addr=%h din=%h stall=%b exp 1 1 010 deadbeef 0",
                     c_gnt, m_we, m_addr, m_din, c_stall);
        end
        @(posedge clk); #1;
        c_we = 1'b0;
        @(negedge clk);
        checks++;
        if (c_gnt !== 1'b1 || m_we !== 1'b0 || m_en !== 1'b1 || c_stall !== 1'b0 || c_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_load_issue got gnt=%b we=%b en=%b stall=%b rvalid=%b exp 1 0 1 0 0",
                     c_gnt, m_we, m_en, c_stall, c_rvalid);
        end
        exp_c.push_back(32'hDEADBEEF);
        @(posedge clk); #1;
        c_req = 1'b0;
        @(negedge clk);
        checks++;
        if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF || c_stall !== 1'b0) begin
            errors++;
            $display("FAIL cpu_load_return got rvalid=%b rdata=%h stall=%b exp 1 deadbeef 0",
                     c_rvalid, c_rdata, c_stall);
        end
    endtask

    task automatic test_loader_burst();
        int  li, k, stalls;
        logic gc, gl;
        @(posedge clk); #1;
        li = 0; k = 0; stalls = 0;
        l_req = 1'b1; l_we = 1'b1; l_addr = 14'h000; l_wdata = 32'hA5A50000;
        while (li < 16 && k < 40) begin
            if (k == 2) begin
                c_req = 1'b1; c_we = 1'b0; c_addr = 14'h010;
            end
            @(negedge clk);
            gc = c_gnt; gl = l_gnt;
            checks++;
            if (gc !== (k == 8) || gl !== (k != 8)) begin
                errors++;
                $display("FAIL ldr_burst_grant cycle=%0d got c=%b l=%b exp c=%b l=%b",
                         k, gc, gl, (k == 8), (k != 8));
            end
            if (c_stall === 1'b1) stalls++;
            if (gc === 1'b1) exp_c.push_back(32'hDEADBEEF);
            if (gl === 1'b1) li++;
            @(posedge clk); #1;
            if (gc === 1'b1) c_req = 1'b0;
            if (li < 16) begin
                l_addr  = AW'(li);
                l_wdata = 32'hA5A50000 + 32'(li);
            end else begin
                l_req = 1'b0;
            end
            k++;
        end
        checks++;
        if (stalls != 6) begin
            errors++;
            $display("FAIL ldr_burst_stall_cycles got=%0d exp=6", stalls);
        end
        checks++;
        if (li != 16 || k != 17) begin
            errors++;
            $display("FAIL ldr_burst_length got grants=%0d cycles=%0d exp 16 17", li, k);
        end
        c_req = 1'b0; l_req = 1'b0;
    endtask

    task automatic test_contention();
        logic exp_cg;
        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 14'h010;
        l_req = 1'b1; l_we = 1'b0; l_addr = 14'h003;
        for (int k = 0; k < 32; k++) begin
            exp_cg = (((k / 8) % 2) == 0);
            @(negedge clk);
            checks++;
            if (c_gnt !== exp_cg || l_gnt !== !exp_cg || c_stall !== !exp_cg) begin
                errors++;
                $display("FAIL contention cycle=%0d got c=%b l=%b stall=%b exp c=%b",
                         k, c_gnt, l_gnt, c_stall, exp_cg);
            end
            if (exp_cg) exp_c.push_back(32'hDEADBEEF);
            else        exp_l.push_back(32'hA5A50003);
            @(posedge clk); #1;
        end
        c_req = 1'b0; l_req = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1;
        l_req = 1'b1; l_we = 1'b0; l_addr = 14'h005;
        @(negedge clk);
        checks++;
        if (l_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrst_grant got=%b exp=1", l_gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (l_gnt !== 1'b0 || m_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async_gate got l_gnt=%b m_en=%b exp 0 0", l_gnt, m_en);
        end
        @(posedge clk); #1;
        checks++;
        if (l_rvalid !== 1'b0 || dut.u_fsm.owner_q !== OWN_IDLE) begin
            errors++;
            $display("FAIL midrst_state got l_rvalid=%b owner=%b exp 0 00", l_rvalid, dut.u_fsm.owner_q);
        end
        rst = 1'b0;
        l_addr = 14'h007;
        @(negedge clk);
        checks++;
        if (l_gnt !== 1'b1 || l_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_regrant got l_gnt=%b l_rvalid=%b exp 1 0", l_gnt, l_rvalid);
        end
        exp_l.push_back(32'hA5A50007);
        @(posedge clk); #1;
        l_req = 1'b0;
    endtask

    task automatic test_burst1();
        logic exp_cg;
        @(posedge clk); #1;
        b_c_req = 1'b1; b_c_we = 1'b1; b_c_addr = 14'h020; b_c_wdata = 32'h11112222;
        b_l_req = 1'b1; b_l_we = 1'b1; b_l_addr = 14'h030; b_l_wdata = 32'h33334444;
        @(negedge clk);
        checks++;
        if (b_c_gnt !== 1'b1 || b_l_gnt !== 1'b0) begin
            errors++;
            $display("FAIL b1_store_first got c=%b l=%b exp 1 0", b_c_gnt, b_l_gnt);
        end
        @(posedge clk); #1;
        b_c_req = 1'b0;
        @(negedge clk);
        checks++;
        if (b_c_gnt !== 1'b0 || b_l_gnt !== 1'b1) begin
            errors++;
            $display("FAIL b1_store_second got c=%b l=%b exp 0 1", b_c_gnt, b_l_gnt);
        end
        @(posedge clk); #1;
        b_l_req = 1'b0;
        @(posedge clk); #1;
        b_c_req = 1'b1; b_c_we = 1'b0;
        b_l_req = 1'b1; b_l_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_cg = ((k % 2) == 0);
            @(negedge clk);
            checks++;
            if (b_c_gnt !== exp_cg || b_l_gnt !== !exp_cg) begin
                errors++;
                $display("FAIL b1_alternate cycle=%0d got c=%b l=%b exp c=%b", k, b_c_gnt, b_l_gnt, exp_cg);
            end
            if (k > 0) begin
                checks++;
                if (b_c_rvalid !== !exp_cg || b_l_rvalid !== exp_cg) begin
                    errors++;
                    $display("FAIL b1_rvalid cycle=%0d got crv=%b lrv=%b exp crv=%b",
                             k, b_c_rvalid, b_l_rvalid, !exp_cg);
                end
            end
            if (exp_cg) exp_bc.push_back(32'h11112222);
            else        exp_bl.push_back(32'h33334444);
            @(posedge clk); #1;
        end
        b_c_req = 1'b0; b_l_req = 1'b0;
    endtask

    initial begin
        b_c_req = 1'b0; b_c_we = 1'b0; b_c_addr = '0; b_c_wdata = '0;
        b_l_req = 1'b0; b_l_we = 1'b0; b_l_addr = '0; b_l_wdata = '0;
        test_reset();
        test_cpu_alone();
        test_loader_burst();
        test_contention();
        test_reset_mid_read();
        test_burst1();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_c.size() != 0 || exp_l.size() != 0 || exp_bc.size() != 0 || exp_bl.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got pending c=%0d l=%0d b1c=%0d b1l=%0d exp all 0",
                     exp_c.size(), exp_l.size(), exp_bc.size(), exp_bl.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the CPU load/store path (port C) and a program/data loader such as a UART boot loader (port L).
- Issues at most one memory access per cycle and returns read data one cycle after issue.
- Stalls the CPU while it is denied.
- Bounds ownership bursts so neither side starves the other.

Parameters:
ADDR_W, 14, word-address width of data memory
DATA_W, 32, data width
BURST_MAX, 8, max consecutive grants to one requester while the other is requesting (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
c_req  in  1  CPU access request, held until c_gnt
c_we  in  1  CPU write enable (1=store, 0=load)
c_addr  in  ADDR_W  CPU word address
c_wdata  in  DATA_W  CPU store data
c_gnt  out  1  CPU access issued this cycle
c_stall  out  1  c_req & ~c_gnt; freezes PC/pipeline
c_rvalid  out  1  CPU read data valid
c_rdata  out  DATA_W  CPU read data
l_req, l_we, l_addr, l_wdata  in  1/1/ADDR_W/DATA_W  loader request bundle, same rules as CPU
l_gnt, l_rvalid  out  1  loader grant / read valid
l_rdata  out  DATA_W  loader read data
m_en  out  1  memory enable
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_din  out  DATA_W  memory write data
m_dout  in  DATA_W  memory read data, valid 1 cycle after m_en & ~m_we

Behaviour:
- Requester rule: req/we/addr/wdata stay stable from req rise until the cycle gnt=1; req may drop or re-request the next cycle.
- Grants are combinational from the registered state/count and the current reqs. c_gnt & l_gnt is never 1. While rst=1, both grants are 0.
- m_en = c_gnt | l_gnt. m_we/m_addr/m_din come from the granted port's inputs; all are 0 when no grant.
- Registered state: owner in {IDLE, CPU, LDR}, cnt in 0..BURST_MAX.
- Arbitration:
  - Only one req: grant it.
  - Both req, owner=IDLE: grant CPU.
  - Both req, owner=X, cnt<BURST_MAX: grant X.
  - Both req, owner=X, cnt==BURST_MAX: grant the other port.
- Next state:
  - Grant to the same owner: cnt=min(cnt+1, BURST_MAX), saturating.
  - Grant to a different owner: owner=new, cnt=1.
  - No req: owner=IDLE, cnt=0.
- Read return:
  - c_rvalid <= c_gnt & ~c_we, registered; l_rvalid likewise.
  - c_rdata = l_rdata = m_dout combinationally; meaningful only when the matching rvalid=1.
  - Writes produce no rvalid.
- Back-to-back accesses are fully pipelined at 1 access/cycle; throughput 1 per cycle.
- Accesses are issued in grant order. A write in cycle T followed by a read of the same address in T+1 returns the new data (memory write-first/ordered).
- Reset (async, any time, including mid-read):
  - owner=IDLE, cnt=0, c_rvalid=l_rvalid=0; a pending read return is discarded.
  - Grants, m_en and c_stall are 0 while rst=1.
  - First grant is possible in the first cycle after rst deasserts.
- c_stall = c_req & ~c_gnt, purely combinational, no added latency.
- BURST_MAX=1 yields strict alternation under contention.

Decomposition:
- Package dmem_arb_pkg holds:
  - owner_t encoding: IDLE=2'b00, CPU=2'b01, LDR=2'b10.
  - Constants OWN_CPU, OWN_LDR.
  - Width defaults ADDR_W/DATA_W.
- One sub-module is natural: dmem_arb_fsm, holding owner/cnt registers and producing the grant select. The top level does request muxing, memory drive and the rvalid registers.

Test Plan:
1. Reset then idle: rst=1 for 3 cycles with c_req=l_req=1 -> c_gnt=l_gnt=m_en=c_rvalid=0, c_stall=0; after release, c_gnt=1 in the first cycle.
2. CPU alone: store 0xDEADBEEF @0x010, then load @0x010 the next cycle -> m_we=1 then m_we=0 on consecutive cycles; c_rvalid=1 with c_rdata=0xDEADBEEF one cycle after the load grant; c_stall=0 throughout.
3. Contention: both request continuously from IDLE, BURST_MAX=8 -> grants are C×8, L×8, C×8, ...; c_stall=1 exactly during the L cycles.
4. Loader burst, CPU arrives late: L writes 0x000..0x00F; CPU load raised at the 3rd L grant -> L keeps 8 total grants (cnt saturated), then C granted next cycle; c_stall high for 6 cycles.
5. Reset mid-read: l_gnt load at T, rst asserted asynchronously before edge T+1 -> l_rvalid stays 0, owner=IDLE; after release, a new L load returns correct data.
6. BURST_MAX=1 override, both requesting -> strict C,L,C,L alternation; rvalid pulses alternate ports one cycle behind grants.
